bit_scan_encoder: RTL and testbench

- Sequential N-to-log2(N) encoder. It is the encode-side counterpart of the team's one-hot decoders (2-to-4, 3-to-8, 4-to-16).
- It accepts a multi-hot request vector and emits the binary index of every set bit, lowest first, one index per output handshake.
- It sits between request-collection logic and consumers that take binary indices, such as decoder-driven select logic.

---
 rtl/bit_scan_pkg.sv | 36 +++
 rtl/prio_enc_lsb.sv | 45 ++++
 rtl/bit_scan_encoder.sv | 77 +++++++
 tb/tb_bit_scan_encoder.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/bit_scan_pkg.sv
// Shared types and reference helpers for the bit-scan encoder.
package bit_scan_pkg;

  // Widest request vector the helpers are written for.
  localparam int MAX_N = 64;

  // Raw state encodings, kept as plain constants for legacy code that compares bits.
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_EMIT = 1'b1;

  typedef enum logic [0:0] {
    IDLE = ST_IDLE,
    EMIT = ST_EMIT
  } state_t;

  // Number of set bits in a (zero-extended) request vector.
  function automatic logic [6:0] popcount(input logic [MAX_N-1:0] vec);
    logic [6:0] cnt;
    cnt = '0;
    for (int i = 0; i < MAX_N; i++) begin
      cnt = cnt + 7'(vec[i]);
    end
    return cnt;
  endfunction

  // Index of the lowest set bit; 0 when the vector is empty.
  function automatic logic [5:0] lowest_set(input logic [MAX_N-1:0] vec);
    logic [5:0] pos;
    pos = '0;
    for (int i = MAX_N - 1; i >= 0; i--) begin
      if (vec[i]) pos = 6'(i);
    end
    return pos;
  endfunction

endpackage

// File: rtl/prio_enc_lsb.sv
// Combinational lowest-set-bit priority encoder, built recursively from two
// halves where the lower half always wins, like the decoders compose.
module prio_enc_lsb #(
  parameter int N = 16,
  localparam int W = $clog2(N)
) (
  input  logic [N-1:0] vec,
  output logic [W-1:0] idx,
  output logic         any,
  output logic         single
);

  if (N == 2) begin : g_leaf
    assign idx    = ~vec[0];
    assign any    = vec[0] | vec[1];
    assign single = vec[0] ^ vec[1];
  end else begin : g_split
    logic [W-2:0] lo_idx;
    logic [W-2:0] hi_idx;
    logic         lo_any;
    logic         hi_any;
    logic         lo_single;
    logic         hi_single;

    prio_enc_lsb #(.N(N/2)) u_lo (
      .vec    (vec[N/2-1:0]),
      .idx    (lo_idx),
      .any    (lo_any),
      .single (lo_single)
    );

    prio_enc_lsb #(.N(N/2)) u_hi (
      .vec    (vec[N-1:N/2]),
      .idx    (hi_idx),
      .any    (hi_any),
      .single (hi_single)
    );

    assign any    = lo_any | hi_any;
    assign idx    = lo_any ? {1'b0, lo_idx} : {1'b1, hi_idx};
    // Exactly one bit overall: one in the lower half and none above, or none below.
    assign single = lo_any ? (lo_single & ~hi_any) : hi_single;
  end

endmodule

// File: rtl/bit_scan_encoder.sv
// Sequential N-to-log2(N) encoder: captures a multi-hot vector and emits the
// index of every set bit, lowest first, one per output handshake.
module bit_scan_encoder #(
  parameter int N = 16,
  parameter int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_vec,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_idx,
  output logic         out_last,
  output logic [W:0]   out_count
);
  import bit_scan_pkg::*;

  state_t         state;
  logic [N-1:0]   pending;
  logic [MAX_N-1:0] in_vec_wide;
  logic [W-1:0]   enc_idx;
  logic           enc_any;
  logic           enc_single;
  logic           emitting;

  prio_enc_lsb #(.N(N)) u_enc (
    .vec    (pending),
    .idx    (enc_idx),
    .any    (enc_any),
    .single (enc_single)
  );

  // Zero-extend the request so the shared popcount helper can be reused at any N.
  always_comb begin
    in_vec_wide          = '0;
    in_vec_wide[N-1:0]   = in_vec;
  end

  // Outputs come only from state and pending; idx/last are forced to 0 outside EMIT.
  always_comb begin
    emitting  = (state == EMIT);
    in_ready  = (state == IDLE);
    out_valid = emitting & enc_any;
    out_idx   = emitting ? enc_idx : '0;
    out_last  = emitting & enc_single;
  end

  // FSM, pending-bit register and captured popcount.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      pending   <= '0;
      out_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            pending   <= in_vec;
            out_count <= (W+1)'(popcount(in_vec_wide));
            if (in_vec != '0) state <= EMIT;
          end
        end
        EMIT: begin
          if (out_ready) begin
            // Clear the lowest set bit, which is the one just handed out.
            pending <= pending & (pending - 1'b1);
            if (enc_single) state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bit_scan_encoder.sv
// Directed testbench for bit_scan_encoder with a queue scoreboard and an
// independent output monitor.
module tb_bit_scan_encoder;

  localparam int N = 16;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in_vec;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_idx;
  logic         out_last;
  logic [W:0]   out_count;

  typedef struct packed {
    logic [W-1:0] idx;
    logic         last;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   rand_ready_on = 1'b0;

  bit_scan_encoder #(.N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_vec    (in_vec),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .out_count (out_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end else begin
      $display("ok   %s: %0d", name, act);
    end
  endtask

  task automatic push_exp(input int idx, input bit last);
    exp_t e;
    e.idx  = idx[W-1:0];
    e.last = last;
    sb.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a vector and hold it until the capturing edge has passed.
  task automatic send(input logic [N-1:0] vec);
    int guard;
    guard = 0;
    while (!in_ready && guard < 100) begin
      step();
      guard++;
    end
    if (!in_ready) chk("in_ready_timeout", 0, 1);
    in_valid = 1'b1;
    in_vec   = vec;
    step();
    in_valid = 1'b0;
    in_vec   = '0;
    $display("sent vector %h", vec);
  endtask

  task automatic wait_idle(input string name);
    int guard;
    guard = 0;
    while (!(in_ready && sb.size() == 0) && guard < 200) begin
      step();
      guard++;
    end
    if (!(in_ready && sb.size() == 0)) chk({name, "_drain_timeout"}, sb.size(), 0);
  endtask

  // Monitor: every accepted output is matched against the head of the scoreboard.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_output: got idx %0d last %0d, expected no output", out_idx, out_last);
      end else begin
        exp_t e;
        e = sb.pop_front();
        n_checks++;
        if (out_idx !== e.idx || out_last !== e.last) begin
          n_fail++;
          $display("FAIL output: got idx %0d last %0d, expected idx %0d last %0d",
                   out_idx, out_last, e.idx, e.last);
        end else begin
          $display("out  idx %0d last %0d", out_idx, out_last);
        end
      end
    end
  end

  // Random consumer backpressure for the last scenario.
  always @(posedge clk) begin
    if (rand_ready_on) begin
      #1;
      out_ready = ($urandom_range(0, 2) != 0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_vec    = '0;
    out_ready = 1'b1;
    step();
    step();

    // Reset state
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_idx", out_idx, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_out_count", out_count, 0);
    rst = 1'b0;
    step();

    // Single bit: one output, then in_ready one cycle later
    push_exp(0, 1'b1);
    send(16'h0001);
    chk("t1_out_valid", out_valid, 1);
    chk("t1_in_ready_low", in_ready, 0);
    chk("t1_count", out_count, 1);
    step();
    chk("t1_in_ready_back", in_ready, 1);
    wait_idle("t1");

    // Four sparse bits at full throughput
    push_exp(0, 1'b0);
    push_exp(5, 1'b0);
    push_exp(10, 1'b0);
    push_exp(15, 1'b1);
    send(16'h8421);
    chk("t2_count", out_count, 4);
    cyc = 0;
    while (!in_ready && cyc < 50) begin
      step();
      cyc++;
    end
    chk("t2_busy_cycles", cyc, 4);
    wait_idle("t2");

    // Zero vector is consumed silently
    send(16'h0000);
    chk("t3_in_ready", in_ready, 1);
    chk("t3_out_valid", out_valid, 0);
    chk("t3_count", out_count, 0);
    step();
    chk("t3_out_valid_later", out_valid, 0);

    // Backpressure holds index and last stable
    out_ready = 1'b0;
    push_exp(1, 1'b0);
    push_exp(2, 1'b1);
    send(16'h0006);
    for (int i = 0; i < 3; i++) begin
      chk("t4_hold_valid", out_valid, 1);
      chk("t4_hold_idx", out_idx, 1);
      chk("t4_hold_last", out_last, 0);
      step();
    end
    out_ready = 1'b1;
    wait_idle("t4");
    chk("t4_count", out_count, 2);

    // Reset in the middle of emitting
    for (int i = 0; i < 16; i++) push_exp(i, i == 15);
    send(16'hFFFF);
    chk("t5_count", out_count, 16);
    step();
    step();
    step();
    rst = 1'b1;
    #1;
    chk("t5_rst_out_valid", out_valid, 0);
    chk("t5_rst_in_ready", in_ready, 1);
    chk("t5_rst_count", out_count, 0);
    chk("t5_accepted_before_rst", 16 - sb.size(), 3);
    sb.delete();
    step();
    rst = 1'b0;
    for (int i = 0; i < 8; i++) step();
    chk("t5_no_residual", out_valid, 0);

    // Full vector with random consumer backpressure
    for (int i = 0; i < 16; i++) push_exp(i, i == 15);
    send(16'hFFFF);
    rand_ready_on = 1'b1;
    wait_idle("t6");
    rand_ready_on = 1'b0;
    #2;
    out_ready = 1'b1;
    chk("t6_count", out_count, 16);
    chk("t6_scoreboard_empty", sb.size(), 0);

    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
